osd_char_overlay: RTL and testbench
===================================

// Module: osd_char_overlay
// PURPOSE
// - Text overlay stage on the video path; directly upstream of char_rom: drives its addr and consumes rd_data.
// - Tracks raster position from de/vs and fetches the character code from a text buffer.
// - Reads the glyph row from char_rom and replaces in-window foreground pixels with FG_COLOR.
// - Video sideband and pixel data are delayed to match the lookup pipeline.
// PARAMETERS
// - WIN_X0      0        first active column of the text window (pixels)
// - WIN_Y0      0        first active line of the text window
// - COLS        80       characters per text row; text_addr = row*COLS + col
// - ROWS        30       text rows
// - CHAR_W      8        glyph width = char_rom data width
// - CHAR_H      16       glyph height, power of 2
// - TXT_AW      12       text buffer address width, >= clog2(COLS*ROWS)
// - TXT_LAT     1        text buffer read latency, cycles (1..2)
// - ROM_LAT     1        char_rom read latency: 1 without output reg, 2 with
// - PIX_W       24       pixel data width
// - FG_COLOR    24'hFFFFFF  overlay foreground colour
// PORTS
// - clk          in   1                  pixel clock
// - rst          in   1                  synchronous, active-high reset
// - enable       in   1                  overlay enable, sampled on vs rising edge only
// - vid_vs       in   1                  vertical sync, active high
// - vid_hs       in   1                  horizontal sync, passed through
// - vid_de       in   1                  active-video qualifier
// - vid_data     in   PIX_W              input pixel
// - txt_rd_en    out  1                  text buffer read strobe
// - txt_addr     out  TXT_AW             text buffer address
// - txt_code     in   8                  char code, valid TXT_LAT cycles after txt_rd_en
// - rom_addr     out  7+clog2(CHAR_H)    to char_rom addr = {code[6:0], yoff}
// - rom_data     in   CHAR_W             from char_rom rd_data, valid ROM_LAT cycles after rom_addr
// - out_vs/out_hs/out_de  out  1         sideband delayed by L
// - out_data     out  PIX_W              overlaid pixel, delayed by L
// BEHAVIOUR
// - Latency L = TXT_LAT + ROM_LAT + 3, fixed, 5 at defaults; every out_* equals in_* delayed L cycles, except out_data.
// - Raster counters:
//   - x increments on each de=1 cycle; reset to 0 on de 1->0.
//   - y increments on de 1->0; reset to 0 on vs 0->1.
//   - Widths clog2(4096).
// - Lock: after rst, locked=0. Set on first vs rising edge; overlay inactive while locked=0.
// - Frame enable: en_f latched from enable at each vs rising edge; mid-frame changes of enable are ignored.
// - In-window: de & locked & en_f & x in [WIN_X0, WIN_X0+COLS*CHAR_W) & y in [WIN_Y0, WIN_Y0+ROWS*CHAR_H).
// - Stage 0 (registered): col=(x-WIN_X0)/CHAR_W, xoff, row=(y-WIN_Y0)/CHAR_H, yoff, in_win.
//   txt_rd_en=in_win; txt_addr=row*COLS+col.
// - Stage 1: after TXT_LAT, register rom_addr={txt_code[6:0],yoff}; inv=txt_code[7].
//   rom_addr holds its last value when not in window.
// - Stage 2: after ROM_LAT, bit=rom_data[CHAR_W-1-xoff]^inv, so the MSB is the leftmost pixel.
//   out_data = (in_win_d & bit) ? FG_COLOR : vid_data_d. Registered.
// - Outside the window or when de=0: out_data = delayed vid_data, unmodified.
// - Reset values: all out_* = 0, txt_rd_en=0, txt_addr=0, rom_addr=0, counters=0, locked=0, en_f=0, pipeline flushed.
// - Reset mid-frame: outputs 0 for the reset cycle. Passthrough resumes L cycles after rst falls. No overlay until the next vs rising edge.
// - vs and de both 1 in the same cycle: y reset takes priority; the pixel counts as line 0.
// - x overflow beyond window width is benign; counters saturate at max and never wrap.
// STRUCTURE
// - Package osd_pkg: CHAR_W/CHAR_H defaults, latency function osd_lat(TXT_LAT,ROM_LAT), raster counter width constant.
// - Sub-module osd_delay_line #(W,DEPTH): shift register. Used for the {vs,hs,de} and vid_data delays and the xoff/inv/in_win alignment.
// - Top level holds the counters, lock/en_f logic and the address arithmetic (mult by COLS only; CHAR_W/CHAR_H are shifts).
// TESTING
// - Reset, then vs pulse, enable=1, de line of 16px, txt_code=8'h41, ROM row=8'hF0, window at 0,0:
//   out_data = FG for px 0-3 and input for px 4-7, starting 5 cycles after de.
// - txt_code=8'hC1, same glyph: px 0-3 pass through, px 4-7 = FG (inverse).
// - WIN_X0=16, line 2: txt_addr=0 issued at x=16. rom_addr={7'h41,4'd2}. Pixels x<16 unmodified.
// - enable toggled 1->0 mid-frame: overlay stays active until next vs rising edge, then all passthrough.
// - rst asserted mid-line for 3 cycles: out_* = 0 during reset. Passthrough resumes after L. No FG until next vs.
// - Sweep TXT_LAT=2, ROM_LAT=2: out_de lags vid_de by exactly 7 cycles; glyph pixels stay aligned.

Source files
------------

// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : osd_pkg
// Description : Shared constants, types and helpers for the OSD text overlay.
//               Holds the default glyph geometry, the raster counter width,
//               the pipeline latency function and the sync sideband bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package osd_pkg;

  localparam int OSD_CHAR_W = 8;
  localparam int OSD_CHAR_H = 16;
  localparam int OSD_RC_W   = $clog2(4096);

  // Video sync sideband carried alongside the pixel data
  typedef struct packed {
    logic vs;
    logic hs;
    logic de;
  } osd_sync_t;

  // Input-to-output latency: stage 0 register, text buffer, rom_addr
  // register, char ROM, output register
  function automatic int osd_lat(input int txt_lat, input int rom_lat);
    return txt_lat + rom_lat + 3;
  endfunction

  // Raster counters stop at all-ones so an over-long line never wraps
  // back into the text window
  function automatic logic [OSD_RC_W-1:0] osd_sat_inc(input logic [OSD_RC_W-1:0] v);
    return (&v) ? v : v + OSD_RC_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/osd_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : osd_delay_line
// Description : Fixed-depth shift register with synchronous clear, used to
//               align sideband, pixel data and lookup side-information with
//               the text/glyph lookup pipeline.
// Ports       : clk  - clock
//               rst  - synchronous active-high clear of every tap
//               din  - W-bit input
//               dout - din delayed by DEPTH cycles (DEPTH >= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module osd_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_taps [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
    end else begin
      r_taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_taps[i] <= r_taps[i-1];
    end
  end

  assign dout = r_taps[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/osd_char_overlay.sv
`default_nettype none
// ============================================================================
// Module      : osd_char_overlay
// Description : Character-cell text overlay on a video stream. Tracks the
//               raster position, reads the character code from a text buffer,
//               reads the glyph row from a char ROM and replaces foreground
//               pixels inside the text window with FG_COLOR. Video sideband
//               and pixels are delayed to match the lookup pipeline.
// Ports       : clk, rst                 - pixel clock, sync active-high reset
//               enable                   - overlay enable, taken at vs rise
//               vid_vs/hs/de, vid_data   - input video
//               txt_rd_en, txt_addr      - text buffer read request
//               txt_code                 - char code, TXT_LAT after request
//               rom_addr                 - char ROM address {code[6:0], yoff}
//               rom_data                 - glyph row, ROM_LAT after rom_addr
//               out_vs/hs/de, out_data   - output video, delayed by latency
// Revision    : 1.0 - initial release
// ============================================================================
module osd_char_overlay
  import osd_pkg::*;
#(
  parameter int              WIN_X0   = 0,
  parameter int              WIN_Y0   = 0,
  parameter int              COLS     = 80,
  parameter int              ROWS     = 30,
  parameter int              CHAR_W   = OSD_CHAR_W,
  parameter int              CHAR_H   = OSD_CHAR_H,
  parameter int              TXT_AW   = 12,
  parameter int              TXT_LAT  = 1,
  parameter int              ROM_LAT  = 1,
  parameter int              PIX_W    = 24,
  parameter logic [PIX_W-1:0] FG_COLOR = 24'hFFFFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        vid_vs,
  input  logic                        vid_hs,
  input  logic                        vid_de,
  input  logic [PIX_W-1:0]            vid_data,
  output logic                        txt_rd_en,
  output logic [TXT_AW-1:0]           txt_addr,
  input  logic [7:0]                  txt_code,
  output logic [6+$clog2(CHAR_H):0]   rom_addr,
  input  logic [CHAR_W-1:0]           rom_data,
  output logic                        out_vs,
  output logic                        out_hs,
  output logic                        out_de,
  output logic [PIX_W-1:0]            out_data
);

  localparam int C_XOFF_W = $clog2(CHAR_W);
  localparam int C_YOFF_W = $clog2(CHAR_H);
  localparam int C_RC_W   = OSD_RC_W;
  localparam int C_LAT    = osd_lat(TXT_LAT, ROM_LAT);
  localparam int C_WIN_W  = COLS * CHAR_W;
  localparam int C_WIN_H  = ROWS * CHAR_H;

  // --------------------------------------------------------------------------
  // Raster tracking, lock and per-frame enable
  // --------------------------------------------------------------------------
  logic              r_vs_prev;
  logic              r_de_prev;
  logic              r_locked;
  logic              r_en_f;
  logic [C_RC_W-1:0] r_x;
  logic [C_RC_W-1:0] r_y;

  logic              w_vs_rise;
  logic              w_de_fall;
  logic [C_RC_W-1:0] w_y_cur;
  logic              w_locked;
  logic              w_en;

  assign w_vs_rise = vid_vs & ~r_vs_prev;
  assign w_de_fall = ~vid_de & r_de_prev;

  // A pixel coinciding with the vs rising edge already belongs to the new
  // frame: line 0, locked, and governed by the freshly sampled enable.
  assign w_y_cur  = w_vs_rise ? '0 : r_y;
  assign w_locked = r_locked | w_vs_rise;
  assign w_en     = w_vs_rise ? enable : r_en_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_prev <= 1'b0;
      r_de_prev <= 1'b0;
      r_locked  <= 1'b0;
      r_en_f    <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vs_prev <= vid_vs;
      r_de_prev <= vid_de;
      if (w_vs_rise) begin
        r_locked <= 1'b1;
        r_en_f   <= enable;
      end
      r_x <= vid_de ? osd_sat_inc(r_x) : '0;
      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall) begin
        r_y <= osd_sat_inc(r_y);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Window test and cell arithmetic. Offsets carry two extra bits; the top
  // bit is the borrow that flags a position left of / above the window.
  // --------------------------------------------------------------------------
  logic [C_RC_W+1:0]          w_xd;
  logic [C_RC_W+1:0]          w_yd;
  logic                       w_in_x;
  logic                       w_in_y;
  logic                       w_in_win;
  logic [C_RC_W-C_XOFF_W-1:0] w_col;
  logic [C_RC_W-C_YOFF_W-1:0] w_row;

  assign w_xd     = {2'b00, r_x}     - (C_RC_W+2)'(WIN_X0);
  assign w_yd     = {2'b00, w_y_cur} - (C_RC_W+2)'(WIN_Y0);
  assign w_in_x   = ~w_xd[C_RC_W+1] & (w_xd[C_RC_W:0] < (C_RC_W+1)'(C_WIN_W));
  assign w_in_y   = ~w_yd[C_RC_W+1] & (w_yd[C_RC_W:0] < (C_RC_W+1)'(C_WIN_H));
  assign w_in_win = vid_de & w_locked & w_en & w_in_x & w_in_y;
  assign w_col    = w_xd[C_RC_W-1:C_XOFF_W];
  assign w_row    = w_yd[C_RC_W-1:C_YOFF_W];

  // --------------------------------------------------------------------------
  // Stage 0: text buffer request; txt_rd_en doubles as the stage-0 in_win
  // --------------------------------------------------------------------------
  logic [C_XOFF_W-1:0] r_s0_xoff;
  logic [C_YOFF_W-1:0] r_s0_yoff;

  always_ff @(posedge clk) begin
    if (rst) begin
      txt_rd_en <= 1'b0;
      txt_addr  <= '0;
      r_s0_xoff <= '0;
      r_s0_yoff <= '0;
    end else begin
      txt_rd_en <= w_in_win;
      r_s0_xoff <= w_xd[C_XOFF_W-1:0];
      r_s0_yoff <= w_yd[C_YOFF_W-1:0];
      if (w_in_win) begin
        txt_addr <= TXT_AW'(int'(w_row) * COLS + int'(w_col));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: glyph row address once the char code arrives
  // --------------------------------------------------------------------------
  logic                w_s1_win;
  logic [C_YOFF_W-1:0] w_s1_yoff;
  logic                r_s1_inv;

  osd_delay_line #(.W(1 + C_YOFF_W), .DEPTH(TXT_LAT)) u_dly_s1 (
    .clk  (clk),
    .rst  (rst),
    .din  ({txt_rd_en, r_s0_yoff}),
    .dout ({w_s1_win, w_s1_yoff})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      r_s1_inv <= 1'b0;
    end else if (w_s1_win) begin
      rom_addr <= {txt_code[6:0], w_s1_yoff};
      r_s1_inv <= txt_code[7];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: pick the glyph bit (MSB = leftmost pixel) and blend
  // --------------------------------------------------------------------------
  logic                w_s2_win;
  logic [C_XOFF_W-1:0] w_s2_xoff;
  logic                w_s2_inv;
  logic [PIX_W-1:0]    w_s2_pix;
  logic [C_XOFF_W-1:0] w_bit_idx;
  logic                w_fg;

  osd_delay_line #(.W(1 + C_XOFF_W), .DEPTH(TXT_LAT + ROM_LAT + 1)) u_dly_s2 (
    .clk  (clk),
    .rst  (rst),
    .din  ({txt_rd_en, r_s0_xoff}),
    .dout ({w_s2_win, w_s2_xoff})
  );

  osd_delay_line #(.W(1), .DEPTH(ROM_LAT)) u_dly_inv (
    .clk  (clk),
    .rst  (rst),
    .din  (r_s1_inv),
    .dout (w_s2_inv)
  );

  osd_delay_line #(.W(PIX_W), .DEPTH(C_LAT - 1)) u_dly_pix (
    .clk  (clk),
    .rst  (rst),
    .din  (vid_data),
    .dout (w_s2_pix)
  );

  assign w_bit_idx = C_XOFF_W'(CHAR_W - 1) - w_s2_xoff;
  assign w_fg      = w_s2_win & (rom_data[w_bit_idx] ^ w_s2_inv);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      out_data <= w_fg ? FG_COLOR : w_s2_pix;
    end
  end

  // --------------------------------------------------------------------------
  // Sideband passthrough, full latency
  // --------------------------------------------------------------------------
  osd_sync_t w_sync_in;
  osd_sync_t w_sync_out;

  assign w_sync_in.vs = vid_vs;
  assign w_sync_in.hs = vid_hs;
  assign w_sync_in.de = vid_de;

  osd_delay_line #(.W($bits(osd_sync_t)), .DEPTH(C_LAT)) u_dly_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (w_sync_in),
    .dout (w_sync_out)
  );

  assign out_vs = w_sync_out.vs;
  assign out_hs = w_sync_out.hs;
  assign out_de = w_sync_out.de;

endmodule
`default_nettype wire

// File: tb/tb_osd_char_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_osd_char_overlay
// Description : Self-checking bench for osd_char_overlay. Two instances share
//               one random video stream: one at latencies 1/1 with the window
//               at the origin, one at latencies 2/2 with an offset window.
//               A frame-level reference model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osd_char_overlay;

  localparam int          NH = 65536;
  localparam logic [23:0] FG = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        vid_vs = 1'b0;
  logic        vid_hs = 1'b0;
  logic        vid_de = 1'b0;
  logic [23:0] vid_data = '0;

  logic        rd_en0, rd_en1;
  logic [11:0] taddr0, taddr1;
  logic [7:0]  tcode0, tcode1;
  logic [10:0] raddr0, raddr1;
  logic [7:0]  rdata0, rdata1;
  logic        ovs0, ohs0, ode0, ovs1, ohs1, ode1;
  logic [23:0] odata0, odata1;

  always #5 clk = ~clk;

  osd_char_overlay #(
    .WIN_X0(0), .WIN_Y0(0), .COLS(8), .ROWS(4), .CHAR_W(8), .CHAR_H(16),
    .TXT_AW(12), .TXT_LAT(1), .ROM_LAT(1), .PIX_W(24), .FG_COLOR(FG)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(enable),
    .vid_vs(vid_vs), .vid_hs(vid_hs), .vid_de(vid_de), .vid_data(vid_data),
    .txt_rd_en(rd_en0), .txt_addr(taddr0), .txt_code(tcode0),
    .rom_addr(raddr0), .rom_data(rdata0),
    .out_vs(ovs0), .out_hs(ohs0), .out_de(ode0), .out_data(odata0)
  );

  osd_char_overlay #(
    .WIN_X0(16), .WIN_Y0(3), .COLS(5), .ROWS(3), .CHAR_W(8), .CHAR_H(16),
    .TXT_AW(12), .TXT_LAT(2), .ROM_LAT(2), .PIX_W(24), .FG_COLOR(FG)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(enable),
    .vid_vs(vid_vs), .vid_hs(vid_hs), .vid_de(vid_de), .vid_data(vid_data),
    .txt_rd_en(rd_en1), .txt_addr(taddr1), .txt_code(tcode1),
    .rom_addr(raddr1), .rom_data(rdata1),
    .out_vs(ovs1), .out_hs(ohs1), .out_de(ode1), .out_data(odata1)
  );

  // Text buffer and char ROM models with the configured read latencies
  logic [7:0] txt_mem [4096];
  logic [7:0] rom_mem [2048];
  logic [7:0] t0_q, r0_q;
  logic [7:0] t1_q [2];
  logic [7:0] r1_q [2];

  always @(posedge clk) begin
    t0_q    <= txt_mem[taddr0];
    r0_q    <= rom_mem[raddr0];
    t1_q[0] <= txt_mem[taddr1];
    t1_q[1] <= t1_q[0];
    r1_q[0] <= rom_mem[raddr1];
    r1_q[1] <= r1_q[0];
  end

  assign tcode0 = t0_q;
  assign rdata0 = r0_q;
  assign tcode1 = t1_q[1];
  assign rdata1 = r1_q[1];

  // Per-cycle history of inputs and model predictions
  bit          h_rst   [NH];
  logic [2:0]  h_sb    [NH];
  logic        h_win   [2][NH];
  logic [11:0] h_addr  [2][NH];
  logic [10:0] h_raddr [2][NH];
  logic [23:0] h_pix   [2][NH];

  int cyc    = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  // Reference raster state
  int m_x = 0, m_y = 0;
  bit m_vsp = 0, m_dep = 0, m_locked = 0, m_en = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // What a pixel at raster (x, y) should become for a given window geometry
  task automatic eval_win(input int wx0, input int wy0, input int cols, input int rows,
                          input int x, input int y, input bit act,
                          output logic win, output logic [11:0] addr,
                          output logic [10:0] ra, output logic [23:0] pix);
    int xr, yr;
    logic [7:0] code, glyph;
    xr   = x - wx0;
    yr   = y - wy0;
    win  = act && xr >= 0 && xr < cols * 8 && yr >= 0 && yr < rows * 16;
    addr = '0;
    ra   = '0;
    pix  = vid_data;
    if (win) begin
      addr  = 12'((yr / 16) * cols + xr / 8);
      code  = txt_mem[addr];
      ra    = {code[6:0], 4'(yr % 16)};
      glyph = rom_mem[ra];
      if (glyph[7 - (xr % 8)] ^ code[7]) pix = FG;
    end
  endtask

  task automatic model_cycle();
    bit vs_rise, act;
    int y_eff;
    vs_rise   = vid_vs && !m_vsp;
    y_eff     = vs_rise ? 0 : m_y;
    act       = vid_de && (m_locked || vs_rise) && (vs_rise ? enable : m_en);
    h_rst[cyc] = rst;
    h_sb[cyc]  = {vid_vs, vid_hs, vid_de};
    eval_win(0, 0, 8, 4, m_x, y_eff, act,
             h_win[0][cyc], h_addr[0][cyc], h_raddr[0][cyc], h_pix[0][cyc]);
    eval_win(16, 3, 5, 3, m_x, y_eff, act,
             h_win[1][cyc], h_addr[1][cyc], h_raddr[1][cyc], h_pix[1][cyc]);
    if (rst) begin
      m_x = 0; m_y = 0; m_vsp = 0; m_dep = 0; m_locked = 0; m_en = 0;
    end else begin
      if (vs_rise) begin
        m_locked = 1;
        m_en     = enable;
        m_y      = 0;
      end else if (m_dep && !vid_de) begin
        m_y = (m_y < 4095) ? m_y + 1 : 4095;
      end
      m_x   = vid_de ? ((m_x < 4095) ? m_x + 1 : 4095) : 0;
      m_vsp = vid_vs;
      m_dep = vid_de;
    end
  endtask

  function automatic bit rst_in(input int a, input int b);
    for (int i = a; i <= b; i++) if (i < 0 || h_rst[i]) return 1;
    return 0;
  endfunction

  task automatic check_cycle();
    int L, T, k;
    logic [23:0] od;
    logic [2:0]  osb;
    logic        ren;
    logic [11:0] ta;
    logic [10:0] ra;
    for (int d = 0; d < 2; d++) begin
      L   = d ? 7 : 5;
      T   = d ? 2 : 1;
      od  = d ? odata1 : odata0;
      osb = d ? {ovs1, ohs1, ode1} : {ovs0, ohs0, ode0};
      ren = d ? rd_en1 : rd_en0;
      ta  = d ? taddr1 : taddr0;
      ra  = d ? raddr1 : raddr0;
      k = cyc - L;
      if (rst_in(k, cyc - 1)) begin
        check_eq($sformatf("d%0d_out_data", d), 64'(od), 64'(0));
        check_eq($sformatf("d%0d_sync", d), 64'(osb), 64'(0));
      end else begin
        check_eq($sformatf("d%0d_out_data", d), 64'(od), 64'(h_pix[d][k]));
        check_eq($sformatf("d%0d_sync", d), 64'(osb), 64'(h_sb[k]));
      end
      k = cyc - 1;
      if (rst_in(k, k)) begin
        check_eq($sformatf("d%0d_rst_rd_en", d), 64'(ren), 64'(0));
        check_eq($sformatf("d%0d_rst_txt_addr", d), 64'(ta), 64'(0));
        check_eq($sformatf("d%0d_rst_rom_addr", d), 64'(ra), 64'(0));
      end else begin
        check_eq($sformatf("d%0d_txt_rd_en", d), 64'(ren), 64'(h_win[d][k]));
        if (h_win[d][k])
          check_eq($sformatf("d%0d_txt_addr", d), 64'(ta), 64'(h_addr[d][k]));
      end
      k = cyc - 2 - T;
      if (k >= 0 && !rst_in(k, cyc - 1) && h_win[d][k])
        check_eq($sformatf("d%0d_rom_addr", d), 64'(ra), 64'(h_raddr[d][k]));
    end
  endtask

  task automatic step(input bit r, input bit v, input bit h, input bit d);
    @(posedge clk);
    #1;
    rst      = r;
    vid_vs   = v;
    vid_hs   = h;
    vid_de   = d;
    vid_data = 24'($urandom);
    model_cycle();
    @(negedge clk);
    check_cycle();
    cyc++;
  endtask

  task automatic do_line(input int len, input int blank, input int vs_cyc, input int rst_at);
    for (int i = 0; i < len; i++)
      step(rst_at >= 0 && i >= rst_at && i < rst_at + 3, i < vs_cyc, 1'b0, 1'b1);
    for (int i = 0; i < blank; i++)
      step(1'b0, 1'b0, i >= 2 && i < 6, 1'b0);
  endtask

  task automatic do_frame(input bit en, input bit toggle, input bit vs_with_de,
                          input int rst_line, input int long_line);
    int len;
    enable = en;
    if (!vs_with_de) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int l = 0; l < 75; l++) begin
      if (toggle && l == 30) enable = ~enable;
      len = (l == long_line) ? 4200 : int'($urandom_range(60, 90));
      do_line(len, int'($urandom_range(8, 14)), (vs_with_de && l == 0) ? 2 : 0,
              (l == rst_line) ? 30 : -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) txt_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
    txt_mem[0]               = 8'h41;
    txt_mem[1]               = 8'hC1;
    rom_mem[{7'h41, 4'd0}]   = 8'hF0;
    rom_mem[{7'h41, 4'd2}]   = 8'hF0;

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    do_line(70, 10, 0, -1);          // enabled but not yet locked
    do_frame(1'b1, 1'b0, 1'b0, -1, -1);
    do_frame(1'b1, 1'b1, 1'b0, -1, -1); // 1->0 mid-frame, still overlaid
    do_frame(1'b0, 1'b1, 1'b0, -1, -1); // 0->1 mid-frame, still passthrough
    do_frame(1'b1, 1'b0, 1'b0, 20, -1); // reset mid-line drops lock
    do_frame(1'b1, 1'b0, 1'b1, -1, -1); // vs rises together with de
    do_frame(1'b1, 1'b0, 1'b0, -1, 5);  // over-long line saturates x
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
